pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register carrying an instruction word and its PC between two pipeline stages, with a valid/ready handshake, synchronous flush that inserts a bubble, and an optional one-entry skid buffer so upstream `in_ready` is fully registered. It replaces the fixed-width IF/ID latch and is instantiated between IF/ID and any later stage pair. Saturating stall and flush counters feed the performance-counter block.

## Interface
- `DATA_W`, 32, instruction/payload width in bits.
- `PC_W`, 32, PC width in bits.
- `RESET_PC`, 32'h0040_0000, `out_pc` value after reset and after flush; truncated to `PC_W`.
- `NOP_INSTR`, 0, `out_instr` value after reset and after flush.
- `SKID`, 1, 1 = two-entry stage with registered `in_ready`; 0 = single entry, `in_ready` combinational from `out_ready`.
- `CNT_W`, 16, width of the statistics counters.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discard all held and incoming beats this cycle.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_instr`  in  DATA_W  upstream instruction.
- `in_pc`  in  PC_W  upstream PC.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a live beat.
- `out_ready`  in  1  downstream consumes the beat this cycle.
- `out_instr`  out  DATA_W  held instruction.
- `out_pc`  out  PC_W  held PC.
- `stall_cycles`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.
- `flush_count`  out  CNT_W  flush cycles that discarded at least one live beat, saturating.

## Operation
- Accept = `in_valid && in_ready`; deliver = `out_valid && out_ready`.
- Occupancy states: EMPTY (0 beats), FULL (1, in output register), SKIDDED (2, second beat in skid register; `SKID=1` only).
- `in_ready`: SKID=1 → `!skid_valid` (registered); SKID=0 → `!out_valid || out_ready`. Forced 0 while `reset` high.
- Output register loads when `!out_valid || out_ready`: from skid if skid valid, else from input if accept, else `out_valid` <= 0 (payload holds last value).
- Accept while output register holds and is not delivered → beat goes to skid (FULL→SKIDDED).
- Transitions: EMPTY–accept→FULL; FULL–deliver, no accept→EMPTY; FULL–deliver+accept→FULL; FULL–accept, no deliver→SKIDDED; SKIDDED–deliver→FULL (skid moves to output); SKIDDED–no deliver→SKIDDED.
- Beat order strictly FIFO; no beat duplicated or dropped except by flush.
- Flush (priority below reset, above everything else): next state EMPTY, `out_valid`=0, skid cleared, `out_pc`=`RESET_PC`, `out_instr`=`NOP_INSTR`; a beat accepted in the flush cycle is discarded. A beat delivered in the flush cycle counts as delivered.
- `flush_count` increments when `flush` and (out_valid or skid valid or accept). `stall_cycles` increments when `out_valid && !out_ready && !flush`. Both saturate at all-ones; cleared only by reset.

## Timing
- Reset values: `out_valid`=0, `out_pc`=`RESET_PC`, `out_instr`=`NOP_INSTR`, skid empty, counters 0, `in_ready`=1 first cycle after reset deasserts.
- Latency: accept in cycle N → `out_valid` in N+1 when EMPTY or FULL-with-deliver.
- Throughput: one beat per cycle sustained with `out_ready` held high.
- SKID=1: `in_ready` drops the cycle after the skid fills, rises the cycle after the skid drains; no combinational path `out_ready`→`in_ready`.
- Reset mid-operation: all beats lost, reset values the next cycle regardless of `flush`/handshake inputs.

## Structure
- Package `pipe_stage_pkg`: occupancy enum (EMPTY/FULL/SKIDDED), default `RESET_PC`, default `NOP_INSTR`.
- Sub-module `pipe_sat_counter` (width param, synchronous clear, increment enable, saturation), instantiated twice.
- SKID=0 elaborates no skid registers.

## Test plan
- Reset: assert `reset` 2 cycles → `out_valid`=0, `out_pc`=0x00400000, `out_instr`=0, counters 0, `in_ready`=1 after release.
- Streaming: 8 beats PC 0x00400000+4k, `out_ready`=1 → each appears 1 cycle after accept, in order, no bubbles.
- Stall/skid (SKID=1): beats A,B, `out_ready`=0 for 3 cycles → A held, B in skid, `in_ready`=0 from cycle after B, `stall_cycles`=3; release → A then B on consecutive cycles.
- Flush while SKIDDED with concurrent accept → next cycle `out_valid`=0, `out_pc`=0x00400000, `out_instr`=0, `flush_count`=1; flush while EMPTY with `in_valid`=0 → `flush_count` unchanged.
- SKID=0 variant: `out_ready`=0 → `in_ready`=0 same cycle; stream order and latency as above.
- Saturation (CNT_W=4): hold stall 20 cycles → `stall_cycles`=15, stays 15.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - occupancy encoding and reset defaults for pipe_stage_reg
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_FULL    = 2'd1,
    OCC_SKIDDED = 2'd2
  } occ_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous clear
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - instruction/PC pipeline stage with handshake, flush and optional skid entry
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          PC_W      = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter bit          SKID      = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [PC_W-1:0]   RST_PC    = PC_W'(RESET_PC);
  localparam logic [DATA_W-1:0] RST_INSTR = DATA_W'(NOP_INSTR);

  occ_e              state;
  occ_e              state_next;
  logic              skid_valid;
  logic              accept;
  logic              deliver;
  logic              load_out;
  logic              stall_inc;
  logic              flush_inc;
  logic [DATA_W-1:0] skid_instr;
  logic [PC_W-1:0]   skid_pc;

  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign load_out  = !out_valid || out_ready;
  assign stall_inc = out_valid && !out_ready && !flush;
  assign flush_inc = flush && (out_valid || skid_valid || accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY:   if (accept) state_next = OCC_FULL;
        OCC_FULL: begin
          if (deliver && !accept) begin
            state_next = OCC_EMPTY;
          end else if (!deliver && accept) begin
            state_next = SKID ? OCC_SKIDDED : OCC_FULL;
          end
        end
        OCC_SKIDDED: if (deliver) state_next = OCC_FULL;
        default:     state_next = OCC_EMPTY;
      endcase
    end
  end

  // With a skid entry, in_ready depends only on the state register.
  always_comb begin
    out_valid  = (state != OCC_EMPTY);
    skid_valid = SKID && (state == OCC_SKIDDED);
    if (reset) begin
      in_ready = 1'b0;
    end else if (SKID) begin
      in_ready = (state != OCC_SKIDDED);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_instr <= RST_INSTR;
      out_pc    <= RST_PC;
    end else if (load_out) begin
      if (skid_valid) begin
        out_instr <= skid_instr;
        out_pc    <= skid_pc;
      end else if (accept) begin
        out_instr <= in_instr;
        out_pc    <= in_pc;
      end
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] skid_instr_q;
      logic [PC_W-1:0]   skid_pc_q;

      // Only a beat accepted while the output holds undelivered lands here.
      always_ff @(posedge clk) begin
        if (accept && !load_out) begin
          skid_instr_q <= in_instr;
          skid_pc_q    <= in_pc;
        end
      end

      assign skid_instr = skid_instr_q;
      assign skid_pc    = skid_pc_q;
    end else begin : g_no_skid
      assign skid_instr = '0;
      assign skid_pc    = '0;
    end
  endgenerate

  pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  pipe_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (skid and no-skid builds)
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [31:0] s1_in_instr, s1_in_pc, s1_out_instr, s1_out_pc;
  logic [3:0]  s1_stall, s1_flushes;

  logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [31:0] s0_in_instr, s0_in_pc, s0_out_instr, s0_out_pc;
  logic [15:0] s0_stall, s0_flushes;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) dut_skid (
    .clk          (clk),
    .reset        (reset),
    .flush        (s1_flush),
    .in_valid     (s1_in_valid),
    .in_ready     (s1_in_ready),
    .in_instr     (s1_in_instr),
    .in_pc        (s1_in_pc),
    .out_valid    (s1_out_valid),
    .out_ready    (s1_out_ready),
    .out_instr    (s1_out_instr),
    .out_pc       (s1_out_pc),
    .stall_cycles (s1_stall),
    .flush_count  (s1_flushes)
  );

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) dut_noskid (
    .clk          (clk),
    .reset        (reset),
    .flush        (s0_flush),
    .in_valid     (s0_in_valid),
    .in_ready     (s0_in_ready),
    .in_instr     (s0_in_instr),
    .in_pc        (s0_in_pc),
    .out_valid    (s0_out_valid),
    .out_ready    (s0_out_ready),
    .out_instr    (s0_out_instr),
    .out_pc       (s0_out_pc),
    .stall_cycles (s0_stall),
    .flush_count  (s0_flushes)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    s1_flush = 0; s1_in_valid = 0; s1_out_ready = 0; s1_in_instr = 0; s1_in_pc = 0;
    s0_flush = 0; s0_in_valid = 0; s0_out_ready = 0; s0_in_instr = 0; s0_in_pc = 0;

    // Reset held two cycles
    tick();
    @(negedge clk);
    check("rst_in_ready_low", s1_in_ready, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", s1_out_valid, 0);
    check("rst_out_pc", s1_out_pc, 32'h0040_0000);
    check("rst_out_instr", s1_out_instr, 0);
    check("rst_stall", s1_stall, 0);
    check("rst_flushes", s1_flushes, 0);
    check("rst_in_ready", s1_in_ready, 1);
    check("rst_s0_in_ready", s0_in_ready, 1);
    tick();

    // Streaming, 8 beats, downstream always ready
    s1_out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      s1_in_valid = 1;
      s1_in_pc    = 32'h0040_0000 + 32'(4 * k);
      s1_in_instr = 32'h0000_1000 + 32'(k);
      @(negedge clk);
      check("stream_in_ready", s1_in_ready, 1);
      if (k > 0) begin
        check("stream_valid", s1_out_valid, 1);
        check("stream_pc", s1_out_pc, 32'h0040_0000 + 32'(4 * (k - 1)));
        check("stream_instr", s1_out_instr, 32'h0000_1000 + 32'(k - 1));
      end
      tick();
    end
    s1_in_valid = 0;
    @(negedge clk);
    check("stream_last_valid", s1_out_valid, 1);
    check("stream_last_pc", s1_out_pc, 32'h0040_001c);
    tick();
    @(negedge clk);
    check("stream_drained", s1_out_valid, 0);
    check("stream_payload_hold", s1_out_pc, 32'h0040_001c);
    check("stream_no_stall", s1_stall, 0);
    tick();

    // Stall with skid: A then B, downstream blocked
    s1_out_ready = 0;
    s1_in_valid = 1; s1_in_pc = 32'h0000_0a00; s1_in_instr = 32'haaaa_0001;
    tick();
    s1_in_valid = 1; s1_in_pc = 32'h0000_0b00; s1_in_instr = 32'hbbbb_0002;
    @(negedge clk);
    check("skid_accept_b", s1_in_ready, 1);
    tick();
    s1_in_valid = 0;
    @(negedge clk);
    check("skid_in_ready_low", s1_in_ready, 0);
    check("skid_hold_a", s1_out_pc, 32'h0000_0a00);
    tick();
    @(negedge clk);
    check("skid_in_ready_low2", s1_in_ready, 0);
    tick();
    s1_out_ready = 1;
    @(negedge clk);
    check("skid_stall3", s1_stall, 3);
    check("skid_out_a", s1_out_instr, 32'haaaa_0001);
    check("skid_ready_still_low", s1_in_ready, 0);
    tick();
    @(negedge clk);
    check("skid_out_b_valid", s1_out_valid, 1);
    check("skid_out_b", s1_out_instr, 32'hbbbb_0002);
    check("skid_ready_back", s1_in_ready, 1);
    tick();
    @(negedge clk);
    check("skid_drained", s1_out_valid, 0);
    tick();

    // Flush while SKIDDED with upstream offering a beat
    s1_out_ready = 0;
    s1_in_valid = 1; s1_in_pc = 32'h0000_0c00; s1_in_instr = 32'hcccc_0003;
    tick();
    s1_in_pc = 32'h0000_0d00; s1_in_instr = 32'hdddd_0004;
    tick();
    s1_flush = 1;
    s1_in_pc = 32'h0000_0e00; s1_in_instr = 32'heeee_0005;
    tick();
    s1_flush = 0; s1_in_valid = 0;
    @(negedge clk);
    check("flush_out_valid", s1_out_valid, 0);
    check("flush_out_pc", s1_out_pc, 32'h0040_0000);
    check("flush_out_instr", s1_out_instr, 0);
    check("flush_count1", s1_flushes, 1);
    check("flush_stall_excl", s1_stall, 4);
    check("flush_in_ready", s1_in_ready, 1);
    tick();
    s1_flush = 1;
    tick();
    s1_flush = 0;
    @(negedge clk);
    check("flush_empty_nocount", s1_flushes, 1);
    tick();
    s1_flush = 1; s1_in_valid = 1; s1_in_pc = 32'h0000_0f00;
    tick();
    s1_flush = 0; s1_in_valid = 0;
    @(negedge clk);
    check("flush_accept_count", s1_flushes, 2);
    check("flush_accept_drop", s1_out_valid, 0);
    tick();

    // Reset mid-operation overrides flush and handshake
    s1_in_valid = 1; s1_in_pc = 32'h0000_1100;
    tick();
    s1_in_valid = 0;
    tick();
    reset = 1; s1_flush = 1; s1_in_valid = 1;
    @(negedge clk);
    check("midrst_in_ready", s1_in_ready, 0);
    tick();
    reset = 0; s1_flush = 0; s1_in_valid = 0;
    @(negedge clk);
    check("midrst_out_valid", s1_out_valid, 0);
    check("midrst_pc", s1_out_pc, 32'h0040_0000);
    check("midrst_stall", s1_stall, 0);
    check("midrst_flushes", s1_flushes, 0);
    tick();

    // Stall counter saturation at 4 bits
    s1_in_valid = 1; s1_in_pc = 32'h0000_1200;
    tick();
    s1_in_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) check("sat_mid", s1_stall, 10);
      tick();
    end
    @(negedge clk);
    check("sat_reached", s1_stall, 15);
    repeat (3) tick();
    @(negedge clk);
    check("sat_stays", s1_stall, 15);
    check("sat_beat_held", s1_out_pc, 32'h0000_1200);
    tick();

    // No-skid build: streaming
    s0_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      s0_in_valid = 1;
      s0_in_pc    = 32'h0040_0000 + 32'(4 * k);
      s0_in_instr = 32'h0000_2000 + 32'(k);
      @(negedge clk);
      check("s0_stream_in_ready", s0_in_ready, 1);
      if (k > 0) check("s0_stream_pc", s0_out_pc, 32'h0040_0000 + 32'(4 * (k - 1)));
      tick();
    end
    s0_in_valid = 0;
    @(negedge clk);
    check("s0_stream_last", s0_out_instr, 32'h0000_2003);
    tick();

    // No-skid build: in_ready follows out_ready combinationally
    s0_out_ready = 0;
    s0_in_valid = 1; s0_in_pc = 32'h0000_3000; s0_in_instr = 32'h3333_0001;
    tick();
    s0_in_pc = 32'h0000_3100; s0_in_instr = 32'h3333_0002;
    #1;
    check("s0_ready_low", s0_in_ready, 0);
    s0_out_ready = 1;
    #1;
    check("s0_ready_high", s0_in_ready, 1);
    check("s0_hold_p", s0_out_instr, 32'h3333_0001);
    tick();
    s0_in_valid = 0;
    @(negedge clk);
    check("s0_out_q", s0_out_instr, 32'h3333_0002);
    check("s0_out_q_valid", s0_out_valid, 1);
    check("s0_stall", s0_stall, 0);
    check("s0_flushes", s0_flushes, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
